// File: rtl/eth_rx_frame_ctrl.sv
// Receive-side Ethernet frame controller: finds the SFD on the PHY symbol stream,
// walks the header/payload/FCS byte stream, filters on destination and reports status.
module eth_rx_frame_ctrl #(
    parameter int          pMII_WIDTH    = 2,
    parameter logic [47:0] pSTATION_ADDR = 48'h02_00_00_00_00_01,
    parameter bit          pPROMISC      = 1'b0,
    parameter int          pIPG_BYTES    = 12
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [pMII_WIDTH-1:0] Rxd,
    input  logic                  Crs_Dv,
    input  logic                  Byte_Rdy,
    input  logic [7:0]            Byte,
    input  logic [31:0]           Crc_Calc,
    output logic                  Rx_En,
    output logic                  Crc_En,
    output logic                  Pay_Vld,
    output logic [7:0]            Pay_Byte,
    output logic [15:0]           Len_Type,
    output logic [15:0]           Pay_Len,
    output logic                  Frame_Done,
    output logic                  Frame_Ok,
    output logic [2:0]            Err_Code
);

    localparam logic [7:0]            PRE_BYTE = 8'h55;
    localparam logic [7:0]            SFD_BYTE = 8'hD5;
    localparam logic [pMII_WIDTH-1:0] PRE_SYM  = PRE_BYTE[pMII_WIDTH-1:0];
    localparam logic [pMII_WIDTH-1:0] SFD_SYM  = SFD_BYTE[7 -: pMII_WIDTH];
    localparam logic [15:0]           IPG_CYC  = 16'(pIPG_BYTES * 8 / pMII_WIDTH);
    localparam logic [3:0]            DROP_CYC = 4'(16 / pMII_WIDTH);
    localparam logic [15:0]           MIN_PAY  = 16'd46;
    localparam logic [15:0]           MAX_PAY  = 16'd1500;
    localparam logic [15:0]           LT_IPV4  = 16'h0800;

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA} sym_state_t;
    typedef enum logic [2:0] {
        B_IDLE, B_DEST, B_SRC, B_LTYPE, B_PAYLOAD, B_FCS, B_CHECK, B_IPG
    } byte_state_t;

    sym_state_t  sym_q, sym_d;
    byte_state_t byte_q, byte_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  drop_q, drop_d;
    logic        uc_match_q, uc_match_d;
    logic        bcast_q, bcast_d;
    logic        type_err_q, type_err_d;
    logic        trunc_q, trunc_d;
    logic [15:0] len_type_q, len_type_d;
    logic [15:0] pay_len_q, pay_len_d;
    logic [15:0] eff_len_q, eff_len_d;
    logic [7:0]  ip_hi_q, ip_hi_d;
    logic [31:0] fcs_q, fcs_d;
    logic        pay_vld_q, pay_vld_d;
    logic [7:0]  pay_byte_q, pay_byte_d;

    logic [7:0]  station_byte [6];
    logic        in_frame, trunc_det, byte_evt, sfd_det, addr_ok;
    logic [15:0] cnt_inc, pay_limit, lt_full, ip_len;
    logic [2:0]  err_code;

    for (genvar gi = 0; gi < 6; gi++) begin : g_station
        assign station_byte[gi] = pSTATION_ADDR[47 - 8*gi -: 8];
    end

    assign in_frame  = (byte_q == B_DEST) || (byte_q == B_SRC) || (byte_q == B_LTYPE) ||
                       (byte_q == B_PAYLOAD) || (byte_q == B_FCS);
    // Truncation fires on the last low cycle and pre-empts any byte strobe in that cycle.
    assign trunc_det = in_frame && !Crs_Dv && (drop_q == DROP_CYC - 4'd1);
    assign byte_evt  = Byte_Rdy && !trunc_det;
    assign sfd_det   = (sym_q == S_PREAMBLE) && Crs_Dv && (Rxd == SFD_SYM);
    assign addr_ok   = pPROMISC || uc_match_q || bcast_q;
    assign cnt_inc   = cnt_q + 16'd1;
    assign pay_limit = (eff_len_q > MIN_PAY) ? eff_len_q : MIN_PAY;
    assign lt_full   = {len_type_q[15:8], Byte};
    assign ip_len    = {ip_hi_q, Byte};

    always_comb begin
        sym_d = sym_q;
        case (sym_q)
            S_IDLE: begin
                if (Crs_Dv && (Rxd == PRE_SYM) && (byte_q == B_IDLE)) sym_d = S_PREAMBLE;
            end
            S_PREAMBLE: begin
                if (!Crs_Dv)             sym_d = S_IDLE;
                else if (Rxd == SFD_SYM) sym_d = S_DATA;
            end
            S_DATA: begin
                if (byte_d == B_CHECK) sym_d = S_IDLE;
            end
            default: sym_d = S_IDLE;
        endcase
    end

    always_comb begin
        byte_d     = byte_q;
        cnt_d      = cnt_q;
        drop_d     = (in_frame && !Crs_Dv) ? drop_q + 4'd1 : 4'd0;
        uc_match_d = uc_match_q;
        bcast_d    = bcast_q;
        type_err_d = type_err_q;
        trunc_d    = trunc_q;
        len_type_d = len_type_q;
        pay_len_d  = pay_len_q;
        eff_len_d  = eff_len_q;
        ip_hi_d    = ip_hi_q;
        fcs_d      = fcs_q;
        pay_vld_d  = 1'b0;
        pay_byte_d = pay_byte_q;

        if (trunc_det) begin
            byte_d  = B_CHECK;
            trunc_d = 1'b1;
            drop_d  = 4'd0;
            cnt_d   = 16'd0;
        end else begin
            case (byte_q)
                B_IDLE: begin
                    if (sfd_det) begin
                        byte_d     = B_DEST;
                        cnt_d      = 16'd0;
                        uc_match_d = 1'b1;
                        bcast_d    = 1'b1;
                        type_err_d = 1'b0;
                        trunc_d    = 1'b0;
                        len_type_d = 16'd0;
                        pay_len_d  = 16'd0;
                        eff_len_d  = 16'd0;
                        fcs_d      = 32'd0;
                    end
                end
                B_DEST: begin
                    if (byte_evt) begin
                        uc_match_d = uc_match_q && (Byte == station_byte[cnt_q[2:0]]);
                        bcast_d    = bcast_q && (Byte == 8'hFF);
                        if (cnt_q == 16'd5) begin
                            byte_d = B_SRC;
                            cnt_d  = 16'd0;
                        end else begin
                            cnt_d  = cnt_inc;
                        end
                    end
                end
                B_SRC: begin
                    if (byte_evt) begin
                        if (cnt_q == 16'd5) begin
                            byte_d = B_LTYPE;
                            cnt_d  = 16'd0;
                        end else begin
                            cnt_d  = cnt_inc;
                        end
                    end
                end
                B_LTYPE: begin
                    if (byte_evt) begin
                        if (cnt_q == 16'd0) begin
                            len_type_d[15:8] = Byte;
                            cnt_d            = cnt_inc;
                        end else begin
                            len_type_d[7:0] = Byte;
                            byte_d          = B_PAYLOAD;
                            cnt_d           = 16'd0;
                            // IPv4 length is unknown until payload byte 3; treat all as data until then.
                            if (lt_full <= MAX_PAY) begin
                                pay_len_d = lt_full;
                                eff_len_d = lt_full;
                            end else if (lt_full == LT_IPV4) begin
                                eff_len_d = MAX_PAY;
                            end else begin
                                type_err_d = 1'b1;
                            end
                        end
                    end
                end
                B_PAYLOAD: begin
                    if (byte_evt) begin
                        pay_vld_d = (cnt_q < eff_len_q) && addr_ok;
                        if (pay_vld_d) pay_byte_d = Byte;
                        if (len_type_q == LT_IPV4 && cnt_q == 16'd2) ip_hi_d = Byte;
                        if (len_type_q == LT_IPV4 && cnt_q == 16'd3) begin
                            if (ip_len > MAX_PAY) begin
                                pay_len_d  = MAX_PAY;
                                eff_len_d  = MAX_PAY;
                                type_err_d = 1'b1;
                            end else begin
                                pay_len_d  = ip_len;
                                eff_len_d  = ip_len;
                            end
                        end
                        if (cnt_inc >= pay_limit) begin
                            byte_d = B_FCS;
                            cnt_d  = 16'd0;
                        end else begin
                            cnt_d  = cnt_inc;
                        end
                    end
                end
                B_FCS: begin
                    if (byte_evt) begin
                        fcs_d[{cnt_q[1:0], 3'b000} +: 8] = Byte;
                        if (cnt_q == 16'd3) begin
                            byte_d = B_CHECK;
                            cnt_d  = 16'd0;
                        end else begin
                            cnt_d  = cnt_inc;
                        end
                    end
                end
                B_CHECK: begin
                    byte_d = B_IPG;
                    cnt_d  = 16'd0;
                end
                B_IPG: begin
                    if (cnt_q == IPG_CYC - 16'd1) begin
                        byte_d = B_IDLE;
                        cnt_d  = 16'd0;
                    end else begin
                        cnt_d  = cnt_inc;
                    end
                end
                default: byte_d = B_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            sym_q      <= S_IDLE;
            byte_q     <= B_IDLE;
            cnt_q      <= 16'd0;
            drop_q     <= 4'd0;
            uc_match_q <= 1'b0;
            bcast_q    <= 1'b0;
            type_err_q <= 1'b0;
            trunc_q    <= 1'b0;
            len_type_q <= 16'd0;
            pay_len_q  <= 16'd0;
            eff_len_q  <= 16'd0;
            ip_hi_q    <= 8'd0;
            fcs_q      <= 32'd0;
            pay_vld_q  <= 1'b0;
            pay_byte_q <= 8'd0;
        end else begin
            sym_q      <= sym_d;
            byte_q     <= byte_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
            uc_match_q <= uc_match_d;
            bcast_q    <= bcast_d;
            type_err_q <= type_err_d;
            trunc_q    <= trunc_d;
            len_type_q <= len_type_d;
            pay_len_q  <= pay_len_d;
            eff_len_q  <= eff_len_d;
            ip_hi_q    <= ip_hi_d;
            fcs_q      <= fcs_d;
            pay_vld_q  <= pay_vld_d;
            pay_byte_q <= pay_byte_d;
        end
    end

    always_comb begin
        err_code = 3'd0;
        if (byte_q == B_CHECK) begin
            if (trunc_q)                err_code = 3'd4;
            else if (type_err_q)        err_code = 3'd3;
            else if (!addr_ok)          err_code = 3'd2;
            else if (Crc_Calc != fcs_q) err_code = 3'd1;
        end
    end

    assign Rx_En      = (sym_q == S_DATA) && !trunc_det;
    assign Crc_En     = (((byte_q == B_DEST) && (cnt_q != 16'd0 || Byte_Rdy)) ||
                         (byte_q == B_SRC) || (byte_q == B_LTYPE) || (byte_q == B_PAYLOAD)) &&
                        !trunc_det;
    assign Pay_Vld    = pay_vld_q;
    assign Pay_Byte   = pay_byte_q;
    assign Len_Type   = len_type_q;
    assign Pay_Len    = pay_len_q;
    assign Frame_Done = (byte_q == B_CHECK);
    assign Frame_Ok   = Frame_Done && (err_code == 3'd0);
    assign Err_Code   = err_code;

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Directed bench: four controllers (MII width 2/4/8, and width 8 promiscuous) see the same
// byte stream; each frame's outcome is checked on the instance the scenario targets.
module tb_eth_rx_frame_ctrl;

    localparam logic [47:0] STATION = 48'h02_00_00_00_00_01;
    localparam logic [31:0] CRC_VAL = 32'hCAFE_BABE;

    logic        clk = 1'b0;
    logic        rst_n, crs_dv, byte_rdy;
    logic [7:0]  rx_byte;
    logic [31:0] crc_calc;
    logic [1:0]  rxd2;
    logic [3:0]  rxd4;
    logic [7:0]  rxd8;

    logic [3:0]  rx_en, crc_en, pay_vld, frame_done, frame_ok;
    logic [7:0]  pay_byte [4];
    logic [15:0] len_type [4];
    logic [15:0] pay_len  [4];
    logic [2:0]  err_code [4];

    int checks = 0;
    int failures = 0;
    int pv_cnt[4], pv_sum[4], done_cnt[4], ok_l[4], code_l[4];
    int pv_base[4], sum_base[4], done_base[4];

    logic [7:0] fbuf [0:1599];
    int         flen;

    always #5 clk = ~clk;

    eth_rx_frame_ctrl #(.pMII_WIDTH(2), .pSTATION_ADDR(STATION), .pPROMISC(1'b0), .pIPG_BYTES(12)) u_w2 (
        .Clk(clk), .Rst_n(rst_n), .Rxd(rxd2), .Crs_Dv(crs_dv), .Byte_Rdy(byte_rdy), .Byte(rx_byte),
        .Crc_Calc(crc_calc), .Rx_En(rx_en[0]), .Crc_En(crc_en[0]), .Pay_Vld(pay_vld[0]),
        .Pay_Byte(pay_byte[0]), .Len_Type(len_type[0]), .Pay_Len(pay_len[0]),
        .Frame_Done(frame_done[0]), .Frame_Ok(frame_ok[0]), .Err_Code(err_code[0]));

    eth_rx_frame_ctrl #(.pMII_WIDTH(4), .pSTATION_ADDR(STATION), .pPROMISC(1'b0), .pIPG_BYTES(12)) u_w4 (
        .Clk(clk), .Rst_n(rst_n), .Rxd(rxd4), .Crs_Dv(crs_dv), .Byte_Rdy(byte_rdy), .Byte(rx_byte),
        .Crc_Calc(crc_calc), .Rx_En(rx_en[1]), .Crc_En(crc_en[1]), .Pay_Vld(pay_vld[1]),
        .Pay_Byte(pay_byte[1]), .Len_Type(len_type[1]), .Pay_Len(pay_len[1]),
        .Frame_Done(frame_done[1]), .Frame_Ok(frame_ok[1]), .Err_Code(err_code[1]));

    eth_rx_frame_ctrl #(.pMII_WIDTH(8), .pSTATION_ADDR(STATION), .pPROMISC(1'b0), .pIPG_BYTES(12)) u_w8 (
        .Clk(clk), .Rst_n(rst_n), .Rxd(rxd8), .Crs_Dv(crs_dv), .Byte_Rdy(byte_rdy), .Byte(rx_byte),
        .Crc_Calc(crc_calc), .Rx_En(rx_en[2]), .Crc_En(crc_en[2]), .Pay_Vld(pay_vld[2]),
        .Pay_Byte(pay_byte[2]), .Len_Type(len_type[2]), .Pay_Len(pay_len[2]),
        .Frame_Done(frame_done[2]), .Frame_Ok(frame_ok[2]), .Err_Code(err_code[2]));

    eth_rx_frame_ctrl #(.pMII_WIDTH(8), .pSTATION_ADDR(STATION), .pPROMISC(1'b1), .pIPG_BYTES(12)) u_w8p (
        .Clk(clk), .Rst_n(rst_n), .Rxd(rxd8), .Crs_Dv(crs_dv), .Byte_Rdy(byte_rdy), .Byte(rx_byte),
        .Crc_Calc(crc_calc), .Rx_En(rx_en[3]), .Crc_En(crc_en[3]), .Pay_Vld(pay_vld[3]),
        .Pay_Byte(pay_byte[3]), .Len_Type(len_type[3]), .Pay_Len(pay_len[3]),
        .Frame_Done(frame_done[3]), .Frame_Ok(frame_ok[3]), .Err_Code(err_code[3]));

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst_n === 1'b1) begin
                if (pay_vld[k] === 1'b1) begin
                    pv_cnt[k] = pv_cnt[k] + 1;
                    pv_sum[k] = pv_sum[k] + int'(pay_byte[k]);
                end
                if (frame_done[k] === 1'b1) begin
                    done_cnt[k] = done_cnt[k] + 1;
                    ok_l[k]     = int'(frame_ok[k]);
                    code_l[k]   = int'(err_code[k]);
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int k = 0; k < 4; k++) begin
            pv_base[k]   = pv_cnt[k];
            sum_base[k]  = pv_sum[k];
            done_base[k] = done_cnt[k];
        end
    endtask

    task automatic report(input string name, input int k);
        $display("frame %s inst=%0d done=%0d ok=%0d code=%0d pay_vld=%0d len_type=%h pay_len=%0d",
                 name, k, done_cnt[k] - done_base[k], ok_l[k], code_l[k], pv_cnt[k] - pv_base[k],
                 len_type[k], pay_len[k]);
    endtask

    task automatic build(input logic [47:0] dst, input logic [15:0] lt, input int plen,
                         input logic [15:0] ip_len, input bit bad_fcs);
        logic [47:0] src;
        src = 48'h02_AA_BB_CC_DD_EE;
        for (int i = 0; i < 6; i++) begin
            fbuf[i]     = dst[47 - 8*i -: 8];
            fbuf[6 + i] = src[47 - 8*i -: 8];
        end
        fbuf[12] = lt[15:8];
        fbuf[13] = lt[7:0];
        for (int i = 0; i < plen; i++) begin
            if (lt == 16'h0800) begin
                case (i)
                    0:       fbuf[14 + i] = 8'h45;
                    1:       fbuf[14 + i] = 8'h00;
                    2:       fbuf[14 + i] = ip_len[15:8];
                    3:       fbuf[14 + i] = ip_len[7:0];
                    default: fbuf[14 + i] = 8'(i);
                endcase
            end else begin
                fbuf[14 + i] = 8'(i + 1);
            end
        end
        for (int i = 0; i < 4; i++) fbuf[14 + plen + i] = CRC_VAL[8*i +: 8];
        if (bad_fcs) fbuf[14 + plen] = fbuf[14 + plen] ^ 8'h01;
        flen = 18 + plen;
    endtask

    // mode 0: complete frame; 1: carrier dropped after nsend bytes; 2: reset after nsend bytes
    task automatic send_frame(input int nsend, input int mode);
        int  cyc;
        bit  got;
        tick();
        crs_dv = 1'b1;
        rxd2 = 2'b01; rxd4 = 4'h5; rxd8 = 8'h55;
        repeat (3) tick();
        rxd2 = 2'b11; rxd4 = 4'hD; rxd8 = 8'hD5;
        tick();
        rxd2 = 2'b00; rxd4 = 4'h0; rxd8 = 8'h00;
        @(negedge clk);
        check_eq("rx_en_after_sfd", rx_en[0], 1'b1);
        check_eq("crc_en_before_dest", crc_en[0], 1'b0);
        tick();
        for (int i = 0; i < nsend; i++) begin
            byte_rdy = 1'b1;
            rx_byte  = fbuf[i];
            @(negedge clk);
            if (i == 0) check_eq("crc_en_first_dest", crc_en[0], 1'b1);
            if (mode == 0 && i == nsend - 5) check_eq("crc_en_last_pay", crc_en[0], 1'b1);
            if (mode == 0 && i == nsend - 4) check_eq("crc_en_fcs", crc_en[0], 1'b0);
            tick();
            byte_rdy = 1'b0;
            tick();
        end
        if (mode == 1) begin
            crs_dv = 1'b0;
            got = 1'b0;
            cyc = 0;
            for (int c = 1; c <= 20 && !got; c++) begin
                @(negedge clk);
                if (frame_done[0] === 1'b1) begin
                    got = 1'b1;
                    cyc = c;
                    check_eq("trunc_crc_en", crc_en[0], 1'b0);
                    check_eq("trunc_rx_en", rx_en[0], 1'b0);
                end
            end
            check_eq("trunc_done_seen", got, 1'b1);
            check_eq("trunc_latency_ok", (cyc <= 9), 1'b1);
            repeat (60) tick();
        end else if (mode == 2) begin
            rst_n    = 1'b0;
            crs_dv   = 1'b0;
            tick();
            @(negedge clk);
            check_eq("rst_mid_rx_en", rx_en[0], 1'b0);
            check_eq("rst_mid_done", frame_done[0], 1'b0);
            tick();
            rst_n = 1'b1;
            repeat (6) tick();
        end else begin
            crs_dv = 1'b0;
            repeat (60) tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; crs_dv = 1'b0; byte_rdy = 1'b0; rx_byte = 8'h00;
        crc_calc = CRC_VAL; rxd2 = 2'b00; rxd4 = 4'h0; rxd8 = 8'h00;
        repeat (3) tick();
        @(negedge clk);
        check_eq("rst_flags", {rx_en, crc_en, pay_vld, frame_done, frame_ok}, 20'h0);
        check_eq("rst_len_type", len_type[0], 16'h0);
        check_eq("rst_pay_len", pay_len[0], 16'h0);
        check_eq("rst_err_code", err_code[0], 3'd0);
        check_eq("rst_pay_byte", pay_byte[0], 8'h0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Unicast, 46-byte payload, width 2
        build(STATION, 16'h002E, 46, 16'h0, 1'b0);
        snap();
        send_frame(flen, 0);
        report("unicast", 0);
        check_eq("uc_pay_cnt", pv_cnt[0] - pv_base[0], 46);
        check_eq("uc_pay_sum", pv_sum[0] - sum_base[0], 1081);
        check_eq("uc_done_cnt", done_cnt[0] - done_base[0], 1);
        check_eq("uc_ok", ok_l[0], 1);
        check_eq("uc_code", code_l[0], 0);
        check_eq("uc_len_type", len_type[0], 16'h002E);
        check_eq("uc_pay_len", pay_len[0], 16'd46);
        check_eq("uc_rx_en_after", rx_en[0], 1'b0);
        check_eq("uc_w8_ok", ok_l[2], 1);

        // IPv4 total length 20 inside a padded 46-byte payload, width 4
        build(STATION, 16'h0800, 46, 16'h0014, 1'b0);
        snap();
        send_frame(flen, 0);
        report("ipv4", 1);
        check_eq("ip_pay_cnt", pv_cnt[1] - pv_base[1], 20);
        check_eq("ip_pay_sum", pv_sum[1] - sum_base[1], 273);
        check_eq("ip_pay_len", pay_len[1], 16'd20);
        check_eq("ip_len_type", len_type[1], 16'h0800);
        check_eq("ip_ok", ok_l[1], 1);

        // Corrupted FCS, width 8
        build(STATION, 16'h002E, 46, 16'h0, 1'b1);
        snap();
        send_frame(flen, 0);
        report("bad_fcs", 2);
        check_eq("crc_done_cnt", done_cnt[2] - done_base[2], 1);
        check_eq("crc_ok", ok_l[2], 0);
        check_eq("crc_code", code_l[2], 1);

        // Destination miss, filtered vs promiscuous
        build(48'h02_00_00_00_00_02, 16'h002E, 46, 16'h0, 1'b0);
        snap();
        send_frame(flen, 0);
        report("addr_miss", 2);
        check_eq("miss_pay_cnt", pv_cnt[2] - pv_base[2], 0);
        check_eq("miss_code", code_l[2], 2);
        check_eq("miss_ok", ok_l[2], 0);
        check_eq("promisc_ok", ok_l[3], 1);
        check_eq("promisc_code", code_l[3], 0);
        check_eq("promisc_pay_cnt", pv_cnt[3] - pv_base[3], 46);

        // Broadcast always accepted
        build(48'hFF_FF_FF_FF_FF_FF, 16'h002E, 46, 16'h0, 1'b0);
        snap();
        send_frame(flen, 0);
        report("broadcast", 2);
        check_eq("bcast_ok", ok_l[2], 1);

        // Unsupported Len_Type
        build(STATION, 16'h1234, 46, 16'h0, 1'b0);
        snap();
        send_frame(flen, 0);
        report("bad_type", 0);
        check_eq("type_code", code_l[0], 3);
        check_eq("type_pay_cnt", pv_cnt[0] - pv_base[0], 0);
        check_eq("type_len_type", len_type[0], 16'h1234);

        // IPv4 length 1536 clamped to 1500
        build(STATION, 16'h0800, 1500, 16'h0600, 1'b0);
        snap();
        send_frame(flen, 0);
        report("ip_clamp", 0);
        check_eq("clamp_pay_len", pay_len[0], 16'd1500);
        check_eq("clamp_code", code_l[0], 3);
        check_eq("clamp_pay_cnt", pv_cnt[0] - pv_base[0], 1500);

        // Carrier lost after payload byte 10
        build(STATION, 16'h002E, 46, 16'h0, 1'b0);
        snap();
        send_frame(14 + 10, 1);
        report("truncated", 0);
        check_eq("trunc_code", code_l[0], 4);
        check_eq("trunc_pay_cnt", pv_cnt[0] - pv_base[0], 10);
        check_eq("trunc_done_cnt", done_cnt[0] - done_base[0], 1);

        // Reset during SRC, then a clean frame
        build(STATION, 16'h002E, 46, 16'h0, 1'b0);
        snap();
        send_frame(9, 2);
        report("reset_abort", 0);
        check_eq("abort_no_done", done_cnt[0] - done_base[0], 0);
        snap();
        send_frame(flen, 0);
        report("after_reset", 0);
        check_eq("post_rst_done", done_cnt[0] - done_base[0], 1);
        check_eq("post_rst_ok", ok_l[0], 1);
        check_eq("post_rst_pay_cnt", pv_cnt[0] - pv_base[0], 46);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
